// File: rtl/dump_window_ctrl_if.sv
// Bundles the dump window controller's stimulus inputs and capture-facing outputs.
// The master side drives the frame sync, download flag and window configuration.
interface dump_window_ctrl_if #(
  parameter int CW = 32
);
  logic          vs;
  logic          downloading;
  logic          enable;
  logic          mode;
  logic [CW-1:0] start_frame;
  logic [CW-1:0] length;
  logic [CW-1:0] frame_cnt;
  logic          dump_on;
  logic          dump_start;
  logic          dump_stop;
  logic [2:0]    state;

  modport master (
    output vs, downloading, enable, mode, start_frame, length,
    input  frame_cnt, dump_on, dump_start, dump_stop, state
  );

  modport slave (
    input  vs, downloading, enable, mode, start_frame, length,
    output frame_cnt, dump_on, dump_start, dump_stop, state
  );
endinterface

// File: rtl/dump_window_ctrl.sv
// Capture window sequencer: counts frames on vs falling edges and opens a dump
// window at a programmed frame or when a ROM download ends.
module dump_window_ctrl #(
  parameter int CW       = 32,
  parameter bit SYNC     = 1'b1,
  parameter int DL_GUARD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dump_window_ctrl_if.slave    bus
);

  localparam int GW = (DL_GUARD < 1) ? 1 : $clog2(DL_GUARD + 1);
  localparam logic [GW-1:0] GUARD_MAX = GW'(DL_GUARD);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_DL = 3'd1,
    ARMED   = 3'd2,
    DUMPING = 3'd3,
    DONE    = 3'd4
  } state_t;

  logic          vs_s;
  logic          dl_s;
  logic          vs_d;
  logic          dl_d;
  logic          vs_fall;
  logic          dl_fall;
  logic          dl_accept;
  logic [GW-1:0] guard_q;
  logic [CW-1:0] frame_q;
  logic [CW-1:0] win_q;
  logic [CW-1:0] win_next;
  state_t        state_q;
  logic          dump_on_q;
  logic          dump_start_q;
  logic          dump_stop_q;

  generate
    if (SYNC) begin : g_sync
      logic vs_m;
      logic dl_m;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vs_m <= 1'b0;
          dl_m <= 1'b0;
          vs_s <= 1'b0;
          dl_s <= 1'b0;
        end else begin
          vs_m <= bus.vs;
          dl_m <= bus.downloading;
          vs_s <= vs_m;
          dl_s <= dl_m;
        end
      end
    end else begin : g_direct
      assign vs_s = bus.vs;
      assign dl_s = bus.downloading;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= 1'b0;
      dl_d <= 1'b0;
    end else begin
      vs_d <= vs_s;
      dl_d <= dl_s;
    end
  end

  assign vs_fall   = vs_d & ~vs_s;
  assign dl_fall   = dl_d & ~dl_s;
  // A download ending right after reset is power-up noise, not a real download.
  assign dl_accept = dl_fall & (guard_q == GUARD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_q <= '0;
    end else if (guard_q != GUARD_MAX) begin
      guard_q <= guard_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (dl_accept) begin
      frame_q <= '0;
    end else if (vs_fall) begin
      frame_q <= frame_q + 1'b1;
    end
  end

  assign win_next = win_q + 1'b1;

  // Disarming wins over every trigger; leaving an open window still reports its close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      win_q        <= '0;
      dump_on_q    <= 1'b0;
      dump_start_q <= 1'b0;
      dump_stop_q  <= 1'b0;
    end else begin
      dump_start_q <= 1'b0;
      dump_stop_q  <= 1'b0;
      if (!bus.enable) begin
        if (state_q == DUMPING) begin
          dump_stop_q <= 1'b1;
        end
        dump_on_q <= 1'b0;
        state_q   <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= bus.mode ? WAIT_DL : ARMED;
          end
          ARMED: begin
            if (vs_fall && (frame_q >= bus.start_frame)) begin
              state_q      <= DUMPING;
              dump_on_q    <= 1'b1;
              dump_start_q <= 1'b1;
              win_q        <= '0;
            end
          end
          WAIT_DL: begin
            if (dl_accept) begin
              state_q      <= DUMPING;
              dump_on_q    <= 1'b1;
              dump_start_q <= 1'b1;
              win_q        <= '0;
            end
          end
          DUMPING: begin
            if (vs_fall) begin
              win_q <= win_next;
              if ((bus.length != '0) && (win_next == bus.length)) begin
                state_q     <= DONE;
                dump_on_q   <= 1'b0;
                dump_stop_q <= 1'b1;
              end
            end
          end
          DONE: begin
            state_q <= DONE;
          end
          default: begin
            state_q   <= IDLE;
            dump_on_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.frame_cnt  = frame_q;
  assign bus.dump_on    = dump_on_q;
  assign bus.dump_start = dump_start_q;
  assign bus.dump_stop  = dump_stop_q;
  assign bus.state      = state_q;

  a_pulses_exclusive: assert property (
    @(posedge clk) disable iff (!rst_n) !(dump_start_q && dump_stop_q)
  );

  a_on_matches_state: assert property (
    @(posedge clk) disable iff (!rst_n) dump_on_q == (state_q == DUMPING)
  );

endmodule

// File: tb/tb_dump_window_ctrl.sv
// Directed bench for dump_window_ctrl: a table-driven frame-trigger run plus
// hand-written download, disarm, wrap and async-reset sequences.
module tb_dump_window_ctrl;

  logic clk;
  logic rst_n;

  dump_window_ctrl_if #(.CW(32)) bus_a ();
  dump_window_ctrl_if #(.CW(4))  bus_b ();

  dump_window_ctrl #(.CW(32), .SYNC(1'b1), .DL_GUARD(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  dump_window_ctrl #(.CW(4), .SYNC(1'b1), .DL_GUARD(16)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    int          pulses;
    logic [31:0] exp_cnt;
    logic        exp_on;
    logic [2:0]  exp_state;
    int          exp_starts;
    int          exp_stops;
  } vec_t;

  vec_t        vecs [6];
  int          compared;
  int          mismatched;
  int          starts_a;
  int          stops_a;
  int          overlap_a;
  int          start_wo_on_a;
  int          stop_with_on_a;
  logic [31:0] prev_cnt_a;
  logic [31:0] cnt_before_stop_a;
  int          base_s;
  int          base_p;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies and the frame count seen just before each close.
  initial begin
    starts_a = 0; stops_a = 0; overlap_a = 0;
    start_wo_on_a = 0; stop_with_on_a = 0;
    prev_cnt_a = '0; cnt_before_stop_a = '1;
    forever begin
      @(negedge clk);
      if (bus_a.dump_start) starts_a++;
      if (bus_a.dump_stop) begin
        stops_a++;
        cnt_before_stop_a = prev_cnt_a;
      end
      if (bus_a.dump_start && bus_a.dump_stop) overlap_a++;
      if (bus_a.dump_start && !bus_a.dump_on) start_wo_on_a++;
      if (bus_a.dump_stop && bus_a.dump_on) stop_with_on_a++;
      prev_cnt_a = bus_a.frame_cnt;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic md,
                                input logic [31:0] sf, input logic [31:0] len);
    bus_a.enable      = en;
    bus_a.mode        = md;
    bus_a.start_frame = sf;
    bus_a.length      = len;
  endtask

  task automatic reset_assert();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_release();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_a();
    bus_a.vs = 1'b1;
    repeat (3) @(negedge clk);
    bus_a.vs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_b();
    bus_b.vs = 1'b1;
    repeat (3) @(negedge clk);
    bus_b.vs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst_n = 1'b0;
    bus_a.vs = 1'b0; bus_a.downloading = 1'b0;
    bus_b.vs = 1'b0; bus_b.downloading = 1'b0;
    bus_b.enable = 1'b0; bus_b.mode = 1'b0;
    bus_b.start_frame = '0; bus_b.length = '0;
    apply_stimulus(1'b1, 1'b0, 32'd5, 32'd3);

    // Frame trigger at 5, three-frame window, ten frames in total.
    vecs[0] = '{pulses: 0, exp_cnt: 32'd0,  exp_on: 1'b0, exp_state: 3'd2, exp_starts: 0, exp_stops: 0};
    vecs[1] = '{pulses: 5, exp_cnt: 32'd5,  exp_on: 1'b0, exp_state: 3'd2, exp_starts: 0, exp_stops: 0};
    vecs[2] = '{pulses: 1, exp_cnt: 32'd6,  exp_on: 1'b1, exp_state: 3'd3, exp_starts: 1, exp_stops: 0};
    vecs[3] = '{pulses: 2, exp_cnt: 32'd8,  exp_on: 1'b1, exp_state: 3'd3, exp_starts: 1, exp_stops: 0};
    vecs[4] = '{pulses: 1, exp_cnt: 32'd9,  exp_on: 1'b0, exp_state: 3'd4, exp_starts: 1, exp_stops: 1};
    vecs[5] = '{pulses: 1, exp_cnt: 32'd10, exp_on: 1'b0, exp_state: 3'd4, exp_starts: 1, exp_stops: 1};

    reset_assert();
    check_output("reset state",      {29'd0, bus_a.state}, 32'd0);
    check_output("reset frame_cnt",  bus_a.frame_cnt, 32'd0);
    check_output("reset dump_on",    {31'd0, bus_a.dump_on}, 32'd0);
    check_output("reset dump_start", {31'd0, bus_a.dump_start}, 32'd0);
    check_output("reset dump_stop",  {31'd0, bus_a.dump_stop}, 32'd0);
    reset_release();

    base_s = starts_a;
    base_p = stops_a;
    for (int i = 0; i < 6; i++) begin
      repeat (vecs[i].pulses) pulse_a();
      if (vecs[i].pulses == 0) repeat (2) @(negedge clk);
      check_output($sformatf("row%0d frame_cnt", i), bus_a.frame_cnt, vecs[i].exp_cnt);
      check_output($sformatf("row%0d dump_on", i), {31'd0, bus_a.dump_on}, {31'd0, vecs[i].exp_on});
      check_output($sformatf("row%0d state", i), {29'd0, bus_a.state}, {29'd0, vecs[i].exp_state});
      check_output($sformatf("row%0d starts", i), starts_a - base_s, vecs[i].exp_starts);
      check_output($sformatf("row%0d stops", i), stops_a - base_p, vecs[i].exp_stops);
    end
    check_output("frame_cnt at close", cnt_before_stop_a, 32'd8);

    // Download trigger: an early download end is ignored by the guard.
    apply_stimulus(1'b1, 1'b1, 32'd0, 32'd0);
    bus_a.downloading = 1'b1;
    reset_assert();
    base_s = starts_a;
    bus_a.vs = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_a.vs = 1'b0;
    repeat (5) @(negedge clk);
    bus_a.downloading = 1'b0;
    repeat (6) @(negedge clk);
    check_output("guard frame_cnt", bus_a.frame_cnt, 32'd1);
    check_output("guard state", {29'd0, bus_a.state}, 32'd1);
    check_output("guard dump_on", {31'd0, bus_a.dump_on}, 32'd0);
    bus_a.downloading = 1'b1;
    repeat (3) pulse_a();
    check_output("dl2 pre frame_cnt", bus_a.frame_cnt, 32'd4);
    repeat (150) @(negedge clk);
    bus_a.downloading = 1'b0;
    repeat (4) @(negedge clk);
    check_output("dl2 frame_cnt", bus_a.frame_cnt, 32'd0);
    check_output("dl2 dump_on", {31'd0, bus_a.dump_on}, 32'd1);
    check_output("dl2 state", {29'd0, bus_a.state}, 32'd3);
    check_output("dl2 starts", starts_a - base_s, 32'd1);

    // Arming after start_frame has already passed, unbounded window.
    apply_stimulus(1'b0, 1'b0, 32'd2, 32'd0);
    reset_assert();
    reset_release();
    repeat (7) pulse_a();
    check_output("late pre frame_cnt", bus_a.frame_cnt, 32'd7);
    check_output("late pre state", {29'd0, bus_a.state}, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'd2, 32'd0);
    repeat (2) @(negedge clk);
    check_output("late armed state", {29'd0, bus_a.state}, 32'd2);
    pulse_a();
    check_output("late open state", {29'd0, bus_a.state}, 32'd3);
    check_output("late open frame_cnt", bus_a.frame_cnt, 32'd8);
    base_p = stops_a;
    repeat (20) pulse_a();
    check_output("unbounded dump_on", {31'd0, bus_a.dump_on}, 32'd1);
    check_output("unbounded frame_cnt", bus_a.frame_cnt, 32'd28);
    check_output("unbounded stops", stops_a - base_p, 32'd0);

    // Disarm mid-window, then re-arm and run a single-frame window.
    bus_a.enable = 1'b0;
    @(negedge clk);
    check_output("disarm dump_stop", {31'd0, bus_a.dump_stop}, 32'd1);
    check_output("disarm dump_on", {31'd0, bus_a.dump_on}, 32'd0);
    check_output("disarm state", {29'd0, bus_a.state}, 32'd0);
    @(negedge clk);
    check_output("disarm stop width", {31'd0, bus_a.dump_stop}, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'd0, 32'd1);
    @(negedge clk);
    check_output("rearm state", {29'd0, bus_a.state}, 32'd2);
    base_p = stops_a;
    pulse_a();
    check_output("len1 open state", {29'd0, bus_a.state}, 32'd3);
    pulse_a();
    check_output("len1 close state", {29'd0, bus_a.state}, 32'd4);
    check_output("len1 dump_on", {31'd0, bus_a.dump_on}, 32'd0);
    check_output("len1 stops", stops_a - base_p, 32'd1);

    // Narrow counter wrap and vs/download falling together.
    reset_assert();
    check_output("b reset frame_cnt", {28'd0, bus_b.frame_cnt}, 32'd0);
    reset_release();
    repeat (20) @(negedge clk);
    for (int i = 1; i <= 17; i++) begin
      pulse_b();
      check_output($sformatf("wrap pulse%0d", i), {28'd0, bus_b.frame_cnt}, i % 16);
    end
    bus_b.vs = 1'b1;
    bus_b.downloading = 1'b1;
    repeat (4) @(negedge clk);
    bus_b.vs = 1'b0;
    bus_b.downloading = 1'b0;
    repeat (4) @(negedge clk);
    check_output("vs+dl frame_cnt", {28'd0, bus_b.frame_cnt}, 32'd0);
    check_output("b idle state", {29'd0, bus_b.state}, 32'd0);

    // Asynchronous reset in the middle of an open window.
    apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0);
    reset_assert();
    reset_release();
    pulse_a();
    check_output("pre-rst dump_on", {31'd0, bus_a.dump_on}, 32'd1);
    base_p = stops_a;
    #2 rst_n = 1'b0;
    #1;
    check_output("async dump_on", {31'd0, bus_a.dump_on}, 32'd0);
    check_output("async state", {29'd0, bus_a.state}, 32'd0);
    check_output("async frame_cnt", bus_a.frame_cnt, 32'd0);
    check_output("async dump_stop", {31'd0, bus_a.dump_stop}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("async no stop", stops_a - base_p, 32'd0);

    check_output("start/stop overlap", overlap_a, 32'd0);
    check_output("start without on", start_wo_on_a, 32'd0);
    check_output("stop with on", stop_with_on_a, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
